aes_key_expand: RTL and testbench
=================================

Name: aes_key_expand

Overview:
- Iterative AES-128 key schedule. Sits directly upstream of the round pipeline and supplies one 128-bit round key per accepted handshake to the round stages' IN_KEY inputs.
- The round-10 key is the one consumed by the final (no-MixColumns) round.
- Generates round keys 0..10 sequentially from a loaded cipher key, with valid/ready backpressure.

Parameters:
- HOLD_LAST, 1: 1 = key_out keeps the round-10 key after completion; 0 = key_out clears to 0 on completion.

Ports:
- clk  in  1  clock, all logic on posedge
- rst  in  1  synchronous active-high reset
- start  in  1  load cipher_key and begin expansion (accepted only when busy=0)
- cipher_key  in  128  AES-128 key; bits [127:96] = w0, byte 0 = MSB
- key_out  out  128  current round key
- key_round  out  4  round index of key_out, 0..10
- key_valid  out  1  key_out/key_round valid
- key_ready  in  1  consumer accepts key when key_valid & key_ready
- key_last  out  1  key_valid & (key_round==10)
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse after round-10 key accepted
- rd_round  in  4  cache read index (feature only)
- rd_key  out  128  cache read data (feature only)

Behaviour:
- Reset:
  - All outputs 0; state IDLE; internal round counter 0.
  - Reset mid-expansion aborts immediately; no done pulse.
- States:
  - IDLE: busy=0, key_valid=0. start=1 -> latch cipher_key into key_out, key_round=0, key_valid=1, go to RUN. First key is visible the cycle after start.
  - RUN: busy=1, key_valid=1. Outputs hold stable while key_ready=0.
    - On handshake with key_round<10: key_out <= expand(key_out, RCON[key_round+1]); key_round += 1; key_valid stays 1.
    - On handshake with key_round==10: go to IDLE, key_valid=0, done=1 for one cycle, key_round=0. key_out is held (HOLD_LAST=1) or cleared (HOLD_LAST=0).
- Throughput: key_ready held high gives 11 consecutive valid cycles; done is asserted on cycle 12 after start.
- start while busy=1: ignored; cipher_key is not sampled.
- start in the same cycle as the final handshake: ignored, because state is still RUN. A new start is accepted from the following cycle.
- expand(w0..w3):
  - t = SubWord(RotWord(w3)) ^ {rcon, 24'h0}
  - RotWord([b0 b1 b2 b3]) = [b1 b2 b3 b0]
  - w4 = w0^t; w5 = w1^w4; w6 = w2^w5; w7 = w3^w6
- RCON[1..10] = 01,02,04,08,10,20,40,80,1B,36.
- Next-key logic is purely combinational from registered key_out: 1-cycle generation, no extra latency.

Optional Feature:
- Macro AES_KEY_CACHE_EN.
- With the macro:
  - 11x128 register array; entry key_round is written on each handshake.
  - rd_key is registered: rd_key <= cache[rd_round], 1-cycle latency.
  - rd_round>10 returns 0.
  - Cache is cleared by rst. It is not cleared by start; entries are overwritten as rounds complete.
  - Intended for decryption, which consumes keys in reverse order.
- Without the macro: no array is built; rd_key is tied to 0 and rd_round is unused.

Decomposition:
- Package aes_pkg:
  - AES_NR=10, KEY_W=128
  - RCON constant array
  - state typedef (IDLE, RUN)
  - sbox function/table shared with the SubBytes stage
- One sub-module: aes_sub_word, a combinational 32-bit SubWord built from 4 S-box lookups, instantiated once.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, key_ready=1:
  - round0 = the input key
  - round1 = a0fafe1788542cb123a339392a6c7605
  - round10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with key_last=1
  - done on cycle 12
- Zero key -> round1 = 62636363626363636263636362636363. Check all 11 keys against the golden model.
- Random key_ready stalls -> key_out/key_round stable while stalled; 11 keys delivered in order, none skipped or repeated; same final key as the unstalled run.
- start pulsed at round 5 with a different key -> ignored; sequence completes with the original key. Restart after done -> new key expands correctly.
- rst asserted at round 4 -> next cycle all outputs 0, busy=0, no done; fresh start works.
- With AES_KEY_CACHE_EN, after the FIPS-197 run:
  - rd_round=10 -> rd_key=d014f9a8c9ee2589e13f0cc8b6630ca6 one cycle later
  - rd_round=12 -> 0
- Without the macro: rd_key always 0.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: sizes, round constants, FSM states, the S-box table
// and the round-key bus type.
package aes_pkg;

  localparam int unsigned AES_NR = 10;
  localparam int unsigned KEY_W  = 128;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned RND_W  = 4;

  localparam logic [RND_W-1:0] LAST_RND = RND_W'(AES_NR);

  // Entry 0 is unused; rounds index RCON[1..10].
  localparam logic [7:0] RCON [AES_NR+1] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic [RND_W-1:0] round;
  } round_key_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// Combinational SubWord: four parallel S-box lookups on a 32-bit word.
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  output logic [WORD_W-1:0] sub_c
);

  always_comb begin
    sub_c = '0;
    for (int i = 0; i < 4; i++) begin
      sub_c[8*i +: 8] = sbox(word[8*i +: 8]);
    end
  end

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule, one round key per valid/ready handshake.
// Optional round-key cache for reverse-order readout: define AES_KEY_CACHE_EN.
module aes_key_expand
  import aes_pkg::*;
#(
  parameter bit HOLD_LAST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [KEY_W-1:0] cipher_key,
  output logic [KEY_W-1:0] key_out,
  output logic [RND_W-1:0] key_round,
  output logic             key_valid,
  input  logic             key_ready,
  output logic             key_last,
  output logic             busy,
  output logic             done,
  input  logic [RND_W-1:0] rd_round,
  output logic [KEY_W-1:0] rd_key
);

  state_t     state_q, state_d;
  round_key_t rk_q, rk_d;
  logic       valid_q, valid_d;
  logic       busy_q, busy_d;
  logic       last_q, last_d;
  logic       done_q, done_d;

  logic [WORD_W-1:0] rot_c, sub_c, t_c;
  logic [WORD_W-1:0] w4_c, w5_c, w6_c, w7_c;
  logic [7:0]        rcon_c;
  logic [KEY_W-1:0]  key_next_c;

  // Next round key straight from the registered current key.
  assign rot_c  = {rk_q.key[23:0], rk_q.key[31:24]};
  assign rcon_c = (rk_q.round < LAST_RND) ? RCON[rk_q.round + RND_W'(1)] : 8'h00;
  assign t_c    = sub_c ^ {rcon_c, 24'h000000};
  assign w4_c   = rk_q.key[127:96] ^ t_c;
  assign w5_c   = rk_q.key[95:64]  ^ w4_c;
  assign w6_c   = rk_q.key[63:32]  ^ w5_c;
  assign w7_c   = rk_q.key[31:0]   ^ w6_c;
  assign key_next_c = {w4_c, w5_c, w6_c, w7_c};

  aes_sub_word u_sub_word (
    .word  (rot_c),
    .sub_c (sub_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rk_q    <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rk_q    <= rk_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  // In RUN key_valid is always high, so key_ready alone marks a handshake.
  always_comb begin
    state_d = state_q;
    rk_d    = rk_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          rk_d.key   = cipher_key;
          rk_d.round = '0;
          state_d    = RUN;
        end
      end
      RUN: begin
        if (key_ready) begin
          if (rk_q.round == LAST_RND) begin
            state_d    = IDLE;
            done_d     = 1'b1;
            rk_d.round = '0;
            if (!HOLD_LAST) rk_d.key = '0;
          end else begin
            rk_d.key   = key_next_c;
            rk_d.round = rk_q.round + RND_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    valid_d = (state_d == RUN);
    busy_d  = (state_d == RUN);
    last_d  = (state_d == RUN) && (rk_d.round == LAST_RND);
  end

  assign key_out   = rk_q.key;
  assign key_round = rk_q.round;
  assign key_valid = valid_q;
  assign busy      = busy_q;
  assign key_last  = last_q;
  assign done      = done_q;

`ifdef AES_KEY_CACHE_EN
  logic [KEY_W-1:0] cache_q [AES_NR+1];
  logic [KEY_W-1:0] rd_key_q;

  // Each accepted key lands in its round slot; reads lag by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cache_q  <= '{default: '0};
      rd_key_q <= '0;
    end else begin
      if ((state_q == RUN) && key_ready) cache_q[rk_q.round] <= rk_q.key;
      rd_key_q <= (rd_round <= LAST_RND) ? cache_q[rd_round] : '0;
    end
  end

  assign rd_key = rd_key_q;
`else
  logic unused_rd_round;
  assign unused_rd_round = ^rd_round;
  assign rd_key          = '0;
`endif

endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand: vector table plus scoreboard queue fed
// by an independent GF(2^8)-derived key-schedule model.
module tb_aes_key_expand;

  localparam bit HOLD_LAST = 1'b1;
  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  logic         clk = 1'b0;
  logic         rst, start, key_ready;
  logic [127:0] cipher_key, key_out, rd_key;
  logic [3:0]   key_round, rd_round;
  logic         key_valid, key_last, busy, done;

  always #5 clk = ~clk;

  aes_key_expand #(.HOLD_LAST(HOLD_LAST)) dut (
    .clk(clk), .rst(rst), .start(start), .cipher_key(cipher_key),
    .key_out(key_out), .key_round(key_round), .key_valid(key_valid),
    .key_ready(key_ready), .key_last(key_last), .busy(busy), .done(done),
    .rd_round(rd_round), .rd_key(rd_key)
  );

  typedef struct {
    logic [127:0] key;
    logic [3:0]   round;
  } exp_t;

  typedef struct {
    logic [127:0] key;
    bit           stall;
    bit           poke;
    logic [127:0] r1;
    logic [127:0] r10;
  } vec_t;

  exp_t       sbq[$];
  vec_t       vecs[5];
  logic [7:0] sb_m [256];
  int         checks = 0;
  int         failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box from first principles: multiplicative inverse then affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] expand_m(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0 = k[127:96], w1 = k[95:64], w2 = k[63:32], w3 = k[31:0];
    logic [31:0] t, w4, w5, w6, w7;
    t  = {sb_m[w3[23:16]], sb_m[w3[15:8]], sb_m[w3[7:0]], sb_m[w3[31:24]]} ^ {rc, 24'h0};
    w4 = w0 ^ t; w5 = w1 ^ w4; w6 = w2 ^ w5; w7 = w3 ^ w6;
    return {w4, w5, w6, w7};
  endfunction

  function automatic logic [127:0] sched_key(input logic [127:0] k, input int n);
    logic [7:0] rc = 8'h01;
    for (int r = 1; r <= n; r++) begin
      k  = expand_m(k, rc);
      rc = xtime(rc);
    end
    return k;
  endfunction

  task automatic push_schedule(input logic [127:0] k);
    for (int r = 0; r <= 10; r++) sbq.push_back('{sched_key(k, r), 4'(r)});
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_key_out"},   key_out, 128'h0);
    chk({tag, "_key_round"}, 128'(key_round), 128'h0);
    chk({tag, "_key_valid"}, 128'(key_valid), 128'h0);
    chk({tag, "_key_last"},  128'(key_last), 128'h0);
    chk({tag, "_busy"},      128'(busy), 128'h0);
    chk({tag, "_done"},      128'(done), 128'h0);
  endtask

  // Drives one full expansion, comparing every accepted key against the queue.
  task automatic run_keys(input logic [127:0] k, input bit stall, input bit poke,
                          output logic [127:0] r1, output logic [127:0] r10, output int done_cyc);
    exp_t e;
    logic [127:0] pk, exp_last;
    logic [3:0] pr;
    bit held = 0, poked = 0, fin = 0;
    r1 = 'x; r10 = 'x; done_cyc = -1; exp_last = 'x; pk = '0; pr = '0;
    @(negedge clk);
    start = 1'b1; cipher_key = k; key_ready = 1'b0;
    push_schedule(k);
    @(negedge clk);
    start = 1'b0; cipher_key = ~k;
    for (int cyc = 1; cyc <= 400 && !fin; cyc++) begin
      if (done) begin
        done_cyc = cyc;
        fin = 1;
      end else begin
        if (cyc == 1) begin
          chk("busy_first", 128'(busy), 128'h1);
          chk("valid_first", 128'(key_valid), 128'h1);
        end
        if (held) begin
          chk("stall_key", key_out, pk);
          chk("stall_round", 128'(key_round), 128'(pr));
        end
        chk("key_last", 128'(key_last), 128'(key_valid && key_round == 4'd10));
        key_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
        start = 1'b0;
        if (poke && !poked && key_round == 4'd5) begin
          start = 1'b1; cipher_key = k ^ 128'hdeadbeef_0badf00d_12345678_9abcdef0; poked = 1;
        end
        if (poke && key_round == 4'd10 && key_ready) begin
          start = 1'b1; cipher_key = ~k;
        end
        if (key_valid && key_ready) begin
          if (sbq.size() == 0) begin
            checks++; failures++;
            $display("FAIL extra_key: got round %0d with empty queue", key_round);
          end else begin
            e = sbq.pop_front();
            chk("key_out", key_out, e.key);
            chk("key_round", 128'(key_round), 128'(e.round));
            exp_last = e.key;
          end
          if (key_round == 4'd1)  r1  = key_out;
          if (key_round == 4'd10) r10 = key_out;
        end
        held = key_valid && !key_ready;
        pk = key_out; pr = key_round;
        @(negedge clk);
      end
    end
    start = 1'b0; key_ready = 1'b0;
    if (!fin) begin
      checks++; failures++;
      $display("FAIL done_timeout: got no done within 400 cycles expected done");
    end
    chk("queue_empty", 128'(sbq.size()), 128'h0);
    sbq.delete();
    chk("done_valid", 128'(key_valid), 128'h0);
    chk("done_busy", 128'(busy), 128'h0);
    chk("done_round", 128'(key_round), 128'h0);
    chk("done_key", key_out, HOLD_LAST ? exp_last : 128'h0);
    @(negedge clk);
    chk("done_pulse", 128'(done), 128'h0);
    chk("idle_after", 128'(key_valid), 128'h0);
  endtask

  task automatic cache_checks(input logic [127:0] r10_exp, input logic [127:0] r0_exp);
    @(negedge clk); rd_round = 4'd10;
    @(negedge clk);
`ifdef AES_KEY_CACHE_EN
    chk("cache_rd10", rd_key, r10_exp);
`else
    chk("rd_key_zero", rd_key, 128'h0);
`endif
    rd_round = 4'd12;
    @(negedge clk);
    chk("cache_rd12", rd_key, 128'h0);
    rd_round = 4'd0;
    @(negedge clk);
`ifdef AES_KEY_CACHE_EN
    chk("cache_rd0", rd_key, r0_exp);
`else
    chk("rd_key_zero", rd_key, 128'h0);
`endif
  endtask

  initial begin
    logic [127:0] r1, r10, rk;
    int dc;
    bit hit;
    rst = 1'b1; start = 1'b0; key_ready = 1'b0; cipher_key = '0; rd_round = '0;
    build_sbox();
    rk = {$urandom, $urandom, $urandom, $urandom};
    vecs[0] = '{FIPS_KEY, 1'b0, 1'b0, FIPS_R1, FIPS_R10};
    vecs[1] = '{128'h0, 1'b0, 1'b0, 128'h62636363626363636263636362636363, sched_key(128'h0, 10)};
    vecs[2] = '{FIPS_KEY, 1'b1, 1'b0, FIPS_R1, FIPS_R10};
    vecs[3] = '{128'h000102030405060708090a0b0c0d0e0f, 1'b0, 1'b1,
                128'hd6aa74fdd2af72fadaa678f1d6ab76fe, 128'h13111d7fe3944a17f307a78b4d2b30c5};
    vecs[4] = '{rk, 1'b1, 1'b1, sched_key(rk, 1), sched_key(rk, 10)};

    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    chk("reset_rd_key", rd_key, 128'h0);
    rst = 1'b0;

    for (int v = 0; v < 5; v++) begin
      run_keys(vecs[v].key, vecs[v].stall, vecs[v].poke, r1, r10, dc);
      chk($sformatf("v%0d_round1", v), r1, vecs[v].r1);
      chk($sformatf("v%0d_round10", v), r10, vecs[v].r10);
      if (!vecs[v].stall) chk($sformatf("v%0d_done_cycle", v), 128'(dc), 128'd12);
      if (v == 0) cache_checks(FIPS_R10, FIPS_KEY);
    end

    // Reset in the middle of an expansion.
    @(negedge clk);
    start = 1'b1; cipher_key = FIPS_KEY;
    @(negedge clk);
    start = 1'b0; key_ready = 1'b1;
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (key_round == 4'd4) hit = 1;
      else @(negedge clk);
    end
    chk("reach_round4", 128'(hit), 128'h1);
    rst = 1'b1;
    @(negedge clk);
    check_idle_zero("rst_mid");
    rst = 1'b0; key_ready = 1'b0;
    @(negedge clk);
    chk("rst_no_done", 128'(done), 128'h0);
    chk("rst_idle", 128'(key_valid), 128'h0);
    cache_checks(128'h0, 128'h0);
    run_keys(FIPS_KEY, 1'b0, 1'b0, r1, r10, dc);
    chk("post_rst_round10", r10, FIPS_R10);
    chk("post_rst_done_cycle", 128'(dc), 128'd12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation stall expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
